// File: rtl/full_adder_serial_if.sv
// Operand/result bundle for the bit-serial adder.
// The master side issues requests; the slave side is the adder itself.
interface full_adder_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, c,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/full_adder_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB first.
// Results are published only on the final RUN edge, so partial sums never appear.
module full_adder_serial #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  full_adder_serial_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             cy_next;
  logic [WIDTH-1:0] res_shift;

  // The single full-adder slice operating on the current LSBs.
  assign s_bit     = a_q[0] ^ b_q[0] ^ cy_q;
  assign cy_next   = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
  assign res_shift = {s_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cy_d    = bus.c;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = res_shift;
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cy_d  = cy_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = res_shift;
          carry_d = cy_next;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule
